dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder: the slave end of the CPU data port (data_addr, b_data_read, b_data_write, write_type, data_in in; data_out, DM_stall out).
- Takes one load/store request at a time and drives a synchronous single-port SRAM macro with configurable read latency.
- Holds DM_stall high until the access completes, then releases the CPU for exactly one cycle.
- Keeps saturating read/write access counters for performance reporting.

Parameters:
- ADDR_W, 14, SRAM word-address width; byte address bits [ADDR_W+1:2] are used.
- LATENCY, 1, cycles from the edge that samples sram_CEB=0 to valid sram_DO; legal values 1..7.
- CNT_W, 32, width of the access counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- data_addr  in  32  byte address from the CPU
- b_data_read  in  1  load request
- b_data_write  in  1  store request
- write_type  in  4  active-low byte write enables; bit i is byte i
- data_in  in  32  store data, already byte-lane aligned
- data_out  out  32  load data, registered
- DM_stall  out  1  CPU must hold the request and freeze the pipeline
- sram_CEB  out  1  SRAM chip enable, active-low
- sram_WEB  out  4  SRAM byte write enables, active-low
- sram_A  out  ADDR_W  SRAM word address
- sram_DI  out  32  SRAM write data
- sram_DO  in  32  SRAM read data
- rd_count  out  CNT_W  completed loads
- wr_count  out  CNT_W  completed stores

Behaviour:
- Request: req = b_data_read | b_data_write.
  - If both are high, the access is a store.
  - A store with write_type=4'b1111 is a handshaked no-op: SRAM is enabled with WEB all 1, and wr_count still increments.
- FSM states: IDLE, BUSY, DONE. Encoding is 2 bits.
- IDLE:
  - DM_stall = req, combinational.
  - On req: latch addr[ADDR_W+1:2], write flag, write_type and data_in; load cnt=LATENCY; go to BUSY.
- BUSY:
  - DM_stall=1.
  - The first BUSY cycle is the issue cycle: sram_CEB=0, sram_A/sram_DI from the latches, sram_WEB = latched write_type for a store, 4'b1111 for a load.
  - In all other BUSY cycles: sram_CEB=1, sram_WEB=4'b1111.
  - cnt decrements each BUSY cycle after the issue cycle. When cnt==0 (for a load): data_out <= sram_DO. Then go to DONE.
  - BUSY lasts LATENCY+1 cycles.
- DONE:
  - DM_stall=0 for exactly one cycle; data_out holds the load result; the CPU advances on this edge.
  - Increment rd_count or wr_count. Counters saturate at all-ones.
  - Next state is IDLE. The request present during DONE is ignored; it belongs to the instruction that is leaving.
- Total stall per access is LATENCY+2 cycles.
- data_out keeps its value across stores and idle cycles; it changes only on load capture.
- sram_A and sram_DI are driven from the latches in all states (no X). sram_CEB=1 except in the issue cycle.
- The request must be stable while DM_stall=1. Inputs are sampled only in IDLE, so later changes are ignored.
- Reset (rst=0, async, any state including mid-BUSY):
  - state=IDLE, cnt=0, latches=0, data_out=0, rd_count=wr_count=0.
  - sram_CEB=1, sram_WEB=4'b1111.
  - DM_stall=0 while in reset.
  - An aborted access is not counted. An in-flight SRAM write is undefined at macro level.
- Address bits above ADDR_W+1 and bits [1:0] are ignored; the address wraps modulo the SRAM size.
- Back-to-back requests: an IDLE cycle always separates DONE from the next capture. Throughput is one access per LATENCY+3 cycles.

Test Plan:
- Reset mid-BUSY: load issued, rst=0 during BUSY, then release → IDLE, DM_stall=0, data_out=0, sram_CEB=1, rd_count=0. A fresh load then completes normally.
- LATENCY=1 load: SRAM word 0x10 = 0xDEADBEEF, data_addr=0x40, b_data_read=1.
  - DM_stall high for cycles 0–2; sram_CEB=0 only in cycle 1 with sram_A=0x10.
  - Cycle 3 (DONE): DM_stall=0, data_out=0xDEADBEEF, rd_count=1.
- Byte store: data_addr=0x44, write_type=4'b1101, data_in=0x0000AB00, b_data_write=1.
  - Issue cycle shows sram_WEB=4'b1101, sram_A=0x11.
  - A following load of 0x44 returns only byte1 changed to 0xAB; wr_count=1.
- LATENCY=3, read and write both high: handled as a store; stall lasts 5 cycles; rd_count unchanged.
- No-op store with write_type=4'b1111: full handshake, SRAM contents unchanged, wr_count increments.
- Saturation (CNT_W=4) and wrap: 17 loads → rd_count=4'hF. A load of data_addr 0xFFFF0040 accesses word 0x10.

Source files
------------

// File: rtl/dm_responder_if.sv
// CPU data-port bundle between the pipeline (master) and the data-memory responder (slave).
interface dm_responder_if;
  logic [31:0] data_addr;
  logic        b_data_read;
  logic        b_data_write;
  logic [3:0]  write_type;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        DM_stall;

  modport master (
    output data_addr, b_data_read, b_data_write, write_type, data_in,
    input  data_out, DM_stall
  );

  modport slave (
    input  data_addr, b_data_read, b_data_write, write_type, data_in,
    output data_out, DM_stall
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one CPU load/store at a time onto a single-port SRAM with
// configurable read latency, stalling the CPU until the access completes.
module dm_responder #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  dm_responder_if.slave     cpu,
  output logic              sram_CEB,
  output logic [3:0]        sram_WEB,
  output logic [ADDR_W-1:0] sram_A,
  output logic [31:0]       sram_DI,
  input  logic [31:0]       sram_DO,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]       LAT     = 3'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic [2:0]          cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [31:0]         di_q;
  logic [31:0]         dout_q;
  logic                ceb_q;
  logic [3:0]          web_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic                req;
  logic                stall;
  logic                unused_addr;

  assign req   = cpu.b_data_read | cpu.b_data_write;
  assign cnt_d = cnt_q - 3'd1;

  // Only the word-address bits reach the macro; the rest wrap away.
  assign unused_addr = ^{cpu.data_addr[31:ADDR_W+2], cpu.data_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      di_q     <= 32'd0;
      dout_q   <= 32'd0;
      ceb_q    <= 1'b1;
      web_q    <= 4'hF;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= cpu.data_addr[ADDR_W+1:2];
            wr_q    <= cpu.b_data_write;
            di_q    <= cpu.data_in;
            cnt_q   <= LAT;
            ceb_q   <= 1'b0;
            web_q   <= cpu.b_data_write ? cpu.write_type : 4'hF;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          ceb_q <= 1'b1;
          web_q <= 4'hF;
          // ceb_q low marks the issue cycle; the latency countdown starts after it.
          if (ceb_q) begin
            cnt_q <= cnt_d;
            if (cnt_d == 3'd0) begin
              if (wr_q) begin
                if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_ONE;
              end else begin
                dout_q <= sram_DO;
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_ONE;
              end
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // In IDLE the stall tracks the request so the CPU freezes in the capture cycle.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = req & rst;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign cpu.DM_stall = stall;
  assign cpu.data_out = dout_q;
  assign sram_CEB     = ceb_q;
  assign sram_WEB     = web_q;
  assign sram_A       = addr_q;
  assign sram_DI      = di_q;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: two instances (LATENCY=1/CNT_W=4 and LATENCY=3/CNT_W=32)
// behind behavioural SRAM models, with a scoreboard of expected completions.
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_responder_if ifa ();
  dm_responder_if ifb ();

  logic        ceb_a, ceb_b;
  logic [3:0]  web_a, web_b;
  logic [13:0] a_a, a_b;
  logic [31:0] di_a, di_b, do_a, do_b;
  logic [3:0]  rdc_a, wrc_a;
  logic [31:0] rdc_b, wrc_b;

  dm_responder #(.ADDR_W(14), .LATENCY(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .cpu(ifa.slave),
    .sram_CEB(ceb_a), .sram_WEB(web_a), .sram_A(a_a), .sram_DI(di_a), .sram_DO(do_a),
    .rd_count(rdc_a), .wr_count(wrc_a)
  );

  dm_responder #(.ADDR_W(14), .LATENCY(3), .CNT_W(32)) u_dut_b (
    .clk(clk), .rst(rst), .cpu(ifb.slave),
    .sram_CEB(ceb_b), .sram_WEB(web_b), .sram_A(a_b), .sram_DI(di_b), .sram_DO(do_b),
    .rd_count(rdc_b), .wr_count(wrc_b)
  );

  // Behavioural SRAM macros: byte-enabled write, read data valid LATENCY edges after issue.
  logic [31:0] mema [0:16383];
  logic [31:0] memb [0:16383];
  logic [31:0] pipeb [0:2];

  always @(posedge clk) begin
    if (!ceb_a) begin
      do_a <= mema[a_a];
      for (int b = 0; b < 4; b++) if (!web_a[b]) mema[a_a][8*b +: 8] <= di_a[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!ceb_b) begin
      pipeb[0] <= memb[a_b];
      for (int b = 0; b < 4; b++) if (!web_b[b]) memb[a_b][8*b +: 8] <= di_b[8*b +: 8];
    end
    pipeb[1] <= pipeb[0];
    pipeb[2] <= pipeb[1];
  end
  assign do_b = pipeb[2];

  // Reference memory contents and expected counters, kept independently of the SRAM models.
  logic [31:0] refa [0:16383];
  logic [31:0] refb [0:16383];
  longint      exp_rd [2];
  longint      exp_wr [2];
  logic [31:0] last_dout [2];

  typedef struct {
    logic [31:0] data;
    longint      rdc;
    longint      wrc;
    int          stall;
    logic [13:0] word;
    logic [3:0]  web;
    logic [31:0] di;
    logic        is_wr;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int sel, input logic [31:0] addr, input logic rd, input logic wr,
                       input logic [3:0] wt, input logic [31:0] din);
    if (sel == 0) begin
      ifa.data_addr = addr; ifa.b_data_read = rd; ifa.b_data_write = wr;
      ifa.write_type = wt; ifa.data_in = din;
    end else begin
      ifb.data_addr = addr; ifb.b_data_read = rd; ifb.b_data_write = wr;
      ifb.write_type = wt; ifb.data_in = din;
    end
  endtask

  // One full CPU access: push the expectation, run the handshake, pop and compare at DONE.
  task automatic access(input int sel, input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [3:0] wt, input logic [31:0] din);
    exp_t        e, got;
    longint      maxc;
    logic        s, ceb, done;
    logic [3:0]  web, iss_web;
    logic [13:0] a, iss_a;
    logic [31:0] di, iss_di, dout;
    longint      rdc, wrc;
    int          stall_n, ceb_low, ceb_idx;

    maxc    = (sel == 0) ? 64'd15 : 64'hFFFF_FFFF;
    e.word  = addr[15:2];
    e.stall = (sel == 0) ? 3 : 5;
    e.is_wr = wr;
    e.di    = din;
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (!wt[b]) begin
          if (sel == 0) refa[e.word][8*b +: 8] = din[8*b +: 8];
          else          refb[e.word][8*b +: 8] = din[8*b +: 8];
        end
      end
      if (exp_wr[sel] < maxc) exp_wr[sel]++;
      e.web = wt;
    end else begin
      last_dout[sel] = (sel == 0) ? refa[e.word] : refb[e.word];
      if (exp_rd[sel] < maxc) exp_rd[sel]++;
      e.web = 4'hF;
    end
    e.data = last_dout[sel];
    e.rdc  = exp_rd[sel];
    e.wrc  = exp_wr[sel];
    sb.push_back(e);

    drive(sel, addr, rd, wr, wt, din);
    stall_n = 0; ceb_low = 0; ceb_idx = -1; done = 1'b0;
    iss_a = '0; iss_web = '0; iss_di = '0; dout = '0; rdc = 0; wrc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        s = ifa.DM_stall; ceb = ceb_a; web = web_a; a = a_a; di = di_a;
        dout = ifa.data_out; rdc = longint'(rdc_a); wrc = longint'(wrc_a);
      end else begin
        s = ifb.DM_stall; ceb = ceb_b; web = web_b; a = a_b; di = di_b;
        dout = ifb.data_out; rdc = longint'(rdc_b); wrc = longint'(wrc_b);
      end
      if (!ceb) begin
        ceb_low++; ceb_idx = k; iss_a = a; iss_web = web; iss_di = di;
      end
      if (!s) begin
        done = 1'b1;
        break;
      end
      stall_n++;
    end
    chk("handshake_timeout", {63'd0, done}, 64'd1);

    got = sb.pop_front();
    chk("stall_cycles", 64'(stall_n), 64'(got.stall));
    chk("ceb_low_count", 64'(ceb_low), 64'd1);
    chk("ceb_issue_cycle", 64'(ceb_idx), 64'd1);
    chk("issue_addr", 64'(iss_a), 64'(got.word));
    chk("issue_web", 64'(iss_web), 64'(got.web));
    if (got.is_wr) chk("issue_di", 64'(iss_di), 64'(got.di));
    chk("data_out", 64'(dout), 64'(got.data));
    chk("rd_count", 64'(rdc), 64'(got.rdc));
    chk("wr_count", 64'(wrc), 64'(got.wrc));
    $display("access dut=%0d addr=%08h rd=%0b wr=%0b wt=%04b din=%08h -> data_out=%08h stall=%0d rd=%0d wr=%0d",
             sel, addr, rd, wr, wt, din, dout, stall_n, rdc, wrc);

    @(posedge clk); #1;
    drive(sel, 32'd0, 1'b0, 1'b0, 4'hF, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 32'd0, 1'b0, 1'b0, 4'hF, 32'd0);
    drive(1, 32'd0, 1'b0, 1'b0, 4'hF, 32'd0);
    for (int i = 0; i < 16384; i++) begin
      mema[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
      memb[i] = 32'hA500_0000 ^ (i * 32'h0003_0001);
      refa[i] = mema[i];
      refb[i] = memb[i];
    end
    mema[16] = 32'hDEAD_BEEF; refa[16] = 32'hDEAD_BEEF;
    mema[17] = 32'h1122_3344; refa[17] = 32'h1122_3344;
    for (int s = 0; s < 2; s++) begin
      exp_rd[s] = 0; exp_wr[s] = 0; last_dout[s] = 32'd0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", 64'(ifa.DM_stall), 64'd0);
    chk("reset_ceb", 64'(ceb_a), 64'd1);
    chk("reset_web", 64'(web_a), 64'hF);
    chk("reset_dout", 64'(ifa.data_out), 64'd0);
    chk("reset_rdc_b", 64'(rdc_b), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset asserted in the middle of a load; the load must not be counted.
    drive(0, 32'h0000_0040, 1'b1, 1'b0, 4'hF, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midbusy_stall_pre", 64'(ifa.DM_stall), 64'd1);
    rst = 1'b0;
    #1;
    chk("midbusy_stall", 64'(ifa.DM_stall), 64'd0);
    chk("midbusy_dout", 64'(ifa.data_out), 64'd0);
    chk("midbusy_ceb", 64'(ceb_a), 64'd1);
    chk("midbusy_web", 64'(web_a), 64'hF);
    chk("midbusy_rdc", 64'(rdc_a), 64'd0);
    drive(0, 32'd0, 1'b0, 1'b0, 4'hF, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst_dout", 64'(ifa.data_out), 64'd0);
    chk("postrst_rdc", 64'(rdc_a), 64'd0);

    access(0, 32'h0000_0040, 1'b1, 1'b0, 4'hF, 32'd0);
    access(0, 32'h0000_0044, 1'b0, 1'b1, 4'b1101, 32'h0000_AB00);
    access(0, 32'h0000_0044, 1'b1, 1'b0, 4'hF, 32'd0);
    chk("byte_store_result", 64'(ifa.data_out), 64'h1122_AB44);

    access(1, 32'h0000_0080, 1'b1, 1'b1, 4'b0000, 32'hCAFE_F00D);
    access(1, 32'h0000_0080, 1'b1, 1'b0, 4'hF, 32'd0);
    access(1, 32'h0000_0080, 1'b0, 1'b1, 4'hF, 32'h1234_5678);
    access(1, 32'h0000_0080, 1'b1, 1'b0, 4'hF, 32'd0);
    chk("noop_store_kept", 64'(ifb.data_out), 64'hCAFE_F00D);

    access(0, 32'hFFFF_0040, 1'b1, 1'b0, 4'hF, 32'd0);
    chk("wrap_data", 64'(ifa.data_out), 64'hDEAD_BEEF);
    for (int i = 0; i < 15; i++) begin
      access(0, (i % 2 == 0) ? 32'h0000_0100 + 32'(i * 4) : 32'h0000_0040, 1'b1, 1'b0, 4'hF, 32'd0);
    end
    chk("rd_saturated", 64'(rdc_a), 64'hF);
    chk("wr_after_sat", 64'(wrc_a), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
